battle_referee: RTL and testbench

BATTLE_REFEREE -- requirements
Module: battle_referee

---
 rtl/tank_game_pkg.sv | 18 +
 rtl/battle_referee_if.sv | 27 ++
 rtl/battle_referee_hit_detect.sv | 14 +
 rtl/battle_referee.sv | 147 ++++++++++++++
 tb/tb_battle_referee.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tank_game_pkg.sv
// Shared types and constants for the tank battle referee: FSM state encoding,
// winner codes and hit-point width.
package tank_game_pkg;

   localparam int HP_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLIGHT = 2'd1,
      JUDGE  = 2'd2,
      OVER   = 2'd3
   } state_t;

   localparam logic [1:0] WINNER_NONE  = 2'b00;
   localparam logic [1:0] WINNER_TANK1 = 2'b01;
   localparam logic [1:0] WINNER_TANK2 = 2'b10;

endpackage

// File: rtl/battle_referee_if.sv
// Signal bundle between the game field (master) and the referee (slave).
interface battle_referee_if;

   logic                            fire;
   logic [7:0]                      shell;
   logic [3:0]                      tank1_loc;
   logic [3:0]                      tank2_loc;
   logic                            restart;
   logic                            turn;
   logic [tank_game_pkg::HP_W-1:0]  hp1;
   logic [tank_game_pkg::HP_W-1:0]  hp2;
   logic                            hit;
   logic [1:0]                      winner;
   logic                            game_over;
   logic                            timeout;

   modport slave (
      input  fire, shell, tank1_loc, tank2_loc, restart,
      output turn, hp1, hp2, hit, winner, game_over, timeout
   );

   modport master (
      output fire, shell, tank1_loc, tank2_loc, restart,
      input  turn, hp1, hp2, hit, winner, game_over, timeout
   );

endinterface

// File: rtl/battle_referee_hit_detect.sv
// Combinational hit test: does the landed shell overlap the target tank's cell?
module hit_detect (
   input  logic [7:0] i_shell_q,
   input  logic       i_turn,
   input  logic [3:0] i_tank1_loc,
   input  logic [3:0] i_tank2_loc,
   output logic       o_hit_raw
);

   // Zero or multi-hot shells fall out of the same AND-reduce; no special case.
   assign o_hit_raw = i_turn ? |(i_shell_q[7:4] & i_tank1_loc)
                             : |(i_shell_q[3:0] & i_tank2_loc);

endmodule

// File: rtl/battle_referee.sv
// Turn-based tank battle referee: tracks turns, hit points and the winner.
// Optional turn-forfeit timer enabled by defining REFEREE_TURN_TIMEOUT_EN.
module battle_referee
   import tank_game_pkg::*;
#(
   parameter int HP_INIT     = 3,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            nrst,
   battle_referee_if.slave bus
);

   if (HP_INIT < 1 || HP_INIT > 3)           $error("HP_INIT out of range");
   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) $error("TIMEOUT_CYC out of range");

   state_t          r_state,     w_state_nxt;
   logic            r_turn,      w_turn_nxt;
   logic [HP_W-1:0] r_hp1,       w_hp1_nxt;
   logic [HP_W-1:0] r_hp2,       w_hp2_nxt;
   logic            r_hit,       w_hit_nxt;
   logic [1:0]      r_winner,    w_winner_nxt;
   logic            r_game_over, w_game_over_nxt;
   logic [7:0]      r_shell_q,   w_shell_q_nxt;
   logic            w_hit_raw;
   logic [HP_W-1:0] w_hp_tgt;
   logic [HP_W-1:0] w_hp_new;
`ifdef REFEREE_TURN_TIMEOUT_EN
   logic [7:0]      r_idle_cnt,  w_idle_cnt_nxt;
   logic            r_timeout,   w_timeout_nxt;
`endif

   hit_detect u_hit_detect (
      .i_shell_q   (r_shell_q),
      .i_turn      (r_turn),
      .i_tank1_loc (bus.tank1_loc),
      .i_tank2_loc (bus.tank2_loc),
      .o_hit_raw   (w_hit_raw)
   );

   // Target is the tank that is not shooting; decrement saturates at zero.
   assign w_hp_tgt = r_turn ? r_hp1 : r_hp2;
   assign w_hp_new = (w_hit_raw && (w_hp_tgt != '0)) ? w_hp_tgt - HP_W'(1) : w_hp_tgt;

   always_comb begin
      // NOTE: every next value gets a default first so no latch is inferred.
      w_state_nxt     = r_state;
      w_turn_nxt      = r_turn;
      w_hp1_nxt       = r_hp1;
      w_hp2_nxt       = r_hp2;
      w_hit_nxt       = 1'b0;
      w_winner_nxt    = r_winner;
      w_game_over_nxt = r_game_over;
      w_shell_q_nxt   = r_shell_q;
`ifdef REFEREE_TURN_TIMEOUT_EN
      w_idle_cnt_nxt  = '0;
      w_timeout_nxt   = 1'b0;
`endif
      unique case (r_state)
         IDLE: begin
            if (bus.fire) begin
               w_state_nxt = FLIGHT;
            end
`ifdef REFEREE_TURN_TIMEOUT_EN
            else if (r_idle_cnt == 8'(TIMEOUT_CYC - 1)) begin
               w_turn_nxt    = ~r_turn;
               w_timeout_nxt = 1'b1;
            end else begin
               w_idle_cnt_nxt = r_idle_cnt + 8'd1;
            end
`endif
         end
         FLIGHT: begin
            w_shell_q_nxt = bus.shell;
            if (!bus.fire) w_state_nxt = JUDGE;
         end
         JUDGE: begin
            w_hit_nxt = w_hit_raw;
            if (r_turn) w_hp1_nxt = w_hp_new;
            else        w_hp2_nxt = w_hp_new;
            if (w_hit_raw && (w_hp_new == '0)) begin
               w_state_nxt     = OVER;
               w_game_over_nxt = 1'b1;
               w_winner_nxt    = r_turn ? WINNER_TANK2 : WINNER_TANK1;
            end else begin
               w_state_nxt = IDLE;
               w_turn_nxt  = ~r_turn;
            end
         end
         OVER: begin
            if (bus.restart) begin
               w_state_nxt     = IDLE;
               w_turn_nxt      = 1'b0;
               w_hp1_nxt       = HP_W'(HP_INIT);
               w_hp2_nxt       = HP_W'(HP_INIT);
               w_winner_nxt    = WINNER_NONE;
               w_game_over_nxt = 1'b0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= IDLE;
         r_turn      <= 1'b0;
         r_hp1       <= HP_W'(HP_INIT);
         r_hp2       <= HP_W'(HP_INIT);
         r_hit       <= 1'b0;
         r_winner    <= WINNER_NONE;
         r_game_over <= 1'b0;
         r_shell_q   <= '0;
`ifdef REFEREE_TURN_TIMEOUT_EN
         r_idle_cnt  <= '0;
         r_timeout   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         r_state     <= w_state_nxt;
         r_turn      <= w_turn_nxt;
         r_hp1       <= w_hp1_nxt;
         r_hp2       <= w_hp2_nxt;
         r_hit       <= w_hit_nxt;
         r_winner    <= w_winner_nxt;
         r_game_over <= w_game_over_nxt;
         r_shell_q   <= w_shell_q_nxt;
`ifdef REFEREE_TURN_TIMEOUT_EN
         r_idle_cnt  <= w_idle_cnt_nxt;
         r_timeout   <= w_timeout_nxt;
`endif
      end
   end

   assign bus.turn      = r_turn;
   assign bus.hp1       = r_hp1;
   assign bus.hp2       = r_hp2;
   assign bus.hit       = r_hit;
   assign bus.winner    = r_winner;
   assign bus.game_over = r_game_over;
`ifdef REFEREE_TURN_TIMEOUT_EN
   assign bus.timeout   = r_timeout;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_battle_referee.sv
// Self-checking bench for battle_referee: directed scenarios plus randomized
// games checked against a game-rule model kept here.
module tb_battle_referee;

   logic clk = 1'b0;
   logic nrst;
   int   total = 0;
   int   bad   = 0;

   battle_referee_if bus ();

   battle_referee #(.HP_INIT(3), .TIMEOUT_CYC(10)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   // Game-rule model: a shot scores if any landed cell coincides with a target cell.
   function automatic bit model_hit(input logic [3:0] field, input logic [3:0] loc);
      for (int p = 0; p < 4; p++)
         if (field[p] && loc[p]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      nrst = 1'b0;
      bus.fire = 1'b0; bus.shell = '0; bus.restart = 1'b0;
      bus.tank1_loc = 4'b0001; bus.tank2_loc = 4'b0001;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
   endtask

   // Starts at a negedge in IDLE; returns at the negedge right after the judgement edge.
   task automatic fly_shot(input int fly, input logic [7:0] land,
                           input logic [3:0] t1, input logic [3:0] t2, input logic [3:0] fl_t2);
      for (int i = 0; i < fly; i++) begin
         bus.fire = 1'b1; bus.shell = 8'($urandom);
         bus.tank1_loc = 4'($urandom); bus.tank2_loc = fl_t2;
         @(negedge clk);
      end
      bus.fire = 1'b0; bus.shell = land; bus.tank1_loc = t1; bus.tank2_loc = t2;
      @(negedge clk);
      bus.shell = 8'($urandom);
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.turn !== 1'b0)      begin bad++; $display("FAIL reset_turn got=%b exp=0", bus.turn); end
      total++; if (bus.hp1 !== 2'd3)       begin bad++; $display("FAIL reset_hp1 got=%0d exp=3", bus.hp1); end
      total++; if (bus.hp2 !== 2'd3)       begin bad++; $display("FAIL reset_hp2 got=%0d exp=3", bus.hp2); end
      total++; if (bus.hit !== 1'b0)       begin bad++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
      total++; if (bus.winner !== 2'b00)   begin bad++; $display("FAIL reset_winner got=%b exp=00", bus.winner); end
      total++; if (bus.game_over !== 1'b0) begin bad++; $display("FAIL reset_over got=%b exp=0", bus.game_over); end
      total++; if (bus.timeout !== 1'b0)   begin bad++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
   endtask

   task automatic test_hit_and_miss();
      do_reset();
      fly_shot(5, 8'b0000_0100, 4'b1000, 4'b0100, 4'b0100);
      total++; if (bus.hit !== 1'b1)  begin bad++; $display("FAIL hit_pulse got=%b exp=1", bus.hit); end
      total++; if (bus.hp2 !== 2'd2)  begin bad++; $display("FAIL hit_hp2 got=%0d exp=2", bus.hp2); end
      total++; if (bus.turn !== 1'b1) begin bad++; $display("FAIL hit_turn got=%b exp=1", bus.turn); end
      @(negedge clk);
      total++; if (bus.hit !== 1'b0)  begin bad++; $display("FAIL hit_one_cycle got=%b exp=0", bus.hit); end
      fly_shot(3, 8'b0010_0000, 4'b0001, 4'b0100, 4'b0100);
      total++; if (bus.hit !== 1'b0)  begin bad++; $display("FAIL miss_hit got=%b exp=0", bus.hit); end
      total++; if (bus.hp1 !== 2'd3)  begin bad++; $display("FAIL miss_hp1 got=%0d exp=3", bus.hp1); end
      total++; if (bus.turn !== 1'b0) begin bad++; $display("FAIL miss_turn got=%b exp=0", bus.turn); end
      @(negedge clk);
   endtask

   task automatic test_loc_change();
      // Location shown during flight differs from the one present at judgement.
      fly_shot(4, 8'b0000_0010, 4'b0001, 4'b0010, 4'b0100);
      total++; if (bus.hit !== 1'b1)  begin bad++; $display("FAIL locchg_hit got=%b exp=1", bus.hit); end
      total++; if (bus.hp2 !== 2'd1)  begin bad++; $display("FAIL locchg_hp2 got=%0d exp=1", bus.hp2); end
      total++; if (bus.turn !== 1'b1) begin bad++; $display("FAIL locchg_turn got=%b exp=1", bus.turn); end
      @(negedge clk);
   endtask

   task automatic test_game_over();
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         fly_shot(2 + k, 8'(1 << (k - 1)), 4'b0100, 4'(1 << (k - 1)), 4'b1000);
         total++; if (bus.hit !== 1'b1)        begin bad++; $display("FAIL go_hit%0d got=%b exp=1", k, bus.hit); end
         total++; if (bus.hp2 !== 2'(3 - k))   begin bad++; $display("FAIL go_hp2_%0d got=%0d exp=%0d", k, bus.hp2, 3 - k); end
         if (k < 3) begin
            @(negedge clk);
            fly_shot(2, 8'b1000_0000, 4'b0001, 4'b0001, 4'b0001);
            total++; if (bus.hp1 !== 2'd3)    begin bad++; $display("FAIL go_miss_hp1 got=%0d exp=3", bus.hp1); end
            total++; if (bus.turn !== 1'b0)   begin bad++; $display("FAIL go_miss_turn got=%b exp=0", bus.turn); end
            @(negedge clk);
         end
      end
      total++; if (bus.game_over !== 1'b1) begin bad++; $display("FAIL go_over got=%b exp=1", bus.game_over); end
      total++; if (bus.winner !== 2'b01)   begin bad++; $display("FAIL go_winner got=%b exp=01", bus.winner); end
      total++; if (bus.turn !== 1'b0)      begin bad++; $display("FAIL go_turn got=%b exp=0", bus.turn); end
      // Fire and landing while OVER must be ignored.
      for (int i = 0; i < 8; i++) begin
         bus.fire = (i < 4); bus.shell = 8'hFF; bus.tank1_loc = 4'hF; bus.tank2_loc = 4'hF;
         @(negedge clk);
         total++; if (bus.hit !== 1'b0 || bus.game_over !== 1'b1 || bus.hp1 !== 2'd3)
            begin bad++; $display("FAIL go_ignore cyc=%0d hit=%b over=%b hp1=%0d exp hit=0 over=1 hp1=3", i, bus.hit, bus.game_over, bus.hp1); end
      end
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      total++; if ({bus.hp1, bus.hp2, bus.turn, bus.winner, bus.game_over} !== {2'd3, 2'd3, 1'b0, 2'b00, 1'b0})
         begin bad++; $display("FAIL restart hp1=%0d hp2=%0d turn=%b winner=%b over=%b exp 3 3 0 00 0", bus.hp1, bus.hp2, bus.turn, bus.winner, bus.game_over); end
      fly_shot(2, 8'b0000_0001, 4'b0001, 4'b0001, 4'b0001);
      total++; if (bus.hit !== 1'b1 || bus.hp2 !== 2'd2)
         begin bad++; $display("FAIL restart_play hit=%b hp2=%0d exp 1 2", bus.hit, bus.hp2); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int          m_hp[2];
      bit          m_turn, m_over, e_hit;
      logic [1:0]  m_winner;
      logic [3:0]  t1, t2, field, tloc;
      logic [7:0]  land;
      int          pos, tgt;
      do_reset();
      m_hp = '{3, 3}; m_turn = 0; m_over = 0; m_winner = 2'b00;
      for (int n = 0; n < 80; n++) begin
         if (m_over) begin
            bus.restart = 1'b1;
            @(negedge clk);
            bus.restart = 1'b0;
            m_hp = '{3, 3}; m_turn = 0; m_over = 0; m_winner = 2'b00;
            total++; if (bus.game_over !== 1'b0 || bus.hp1 !== 2'd3 || bus.hp2 !== 2'd3 || bus.turn !== 1'b0)
               begin bad++; $display("FAIL rnd_restart over=%b hp1=%0d hp2=%0d turn=%b exp 0 3 3 0", bus.game_over, bus.hp1, bus.hp2, bus.turn); end
         end
         t1 = 4'(1 << $urandom_range(0, 3));
         t2 = 4'(1 << $urandom_range(0, 3));
         tloc = m_turn ? t1 : t2;
         pos = $urandom_range(0, 3);
         field = $urandom_range(0, 1) ? tloc : 4'(1 << pos);
         land = m_turn ? {field, 4'($urandom)} : {4'($urandom), field};
         if ($urandom_range(0, 7) == 0) land = 8'($urandom);
         fly_shot($urandom_range(1, 6), land, t1, t2, 4'($urandom));
         e_hit = model_hit(m_turn ? land[7:4] : land[3:0], tloc);
         tgt = m_turn ? 0 : 1;
         if (e_hit && m_hp[tgt] > 0) m_hp[tgt]--;
         if (e_hit && m_hp[tgt] == 0) begin
            m_over = 1; m_winner = m_turn ? 2'b10 : 2'b01;
         end else m_turn = ~m_turn;
         total++;
         if (bus.hit !== e_hit || bus.hp1 !== 2'(m_hp[0]) || bus.hp2 !== 2'(m_hp[1]) ||
             bus.turn !== m_turn || bus.winner !== m_winner || bus.game_over !== m_over) begin
            bad++;
            $display("FAIL rnd_shot%0d got hit=%b hp=%0d/%0d turn=%b win=%b over=%b exp hit=%b hp=%0d/%0d turn=%b win=%b over=%b",
                     n, bus.hit, bus.hp1, bus.hp2, bus.turn, bus.winner, bus.game_over,
                     e_hit, m_hp[0], m_hp[1], m_turn, m_winner, m_over);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_flight();
      do_reset();
      fly_shot(2, 8'b0000_0001, 4'b0001, 4'b0001, 4'b0001);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.fire = 1'b1; bus.shell = 8'b0001_0000; bus.tank1_loc = 4'b0001;
         @(negedge clk);
      end
      #2 nrst = 1'b0; bus.fire = 1'b0;
      #1;
      total++; if ({bus.turn, bus.hp1, bus.hp2, bus.hit, bus.winner, bus.game_over} !== {1'b0, 2'd3, 2'd3, 1'b0, 2'b00, 1'b0})
         begin bad++; $display("FAIL midrst_async turn=%b hp=%0d/%0d hit=%b exp 0 3/3 0", bus.turn, bus.hp1, bus.hp2, bus.hit); end
      @(negedge clk);
      nrst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (bus.hit !== 1'b0 || bus.hp1 !== 2'd3 || bus.turn !== 1'b0)
            begin bad++; $display("FAIL midrst_after cyc=%0d hit=%b hp1=%0d turn=%b exp 0 3 0", i, bus.hit, bus.hp1, bus.turn); end
      end
   endtask

   task automatic test_timeout();
      do_reset();
`ifdef REFEREE_TURN_TIMEOUT_EN
      for (int k = 1; k <= 19; k++) begin
         if (k == 19) bus.fire = 1'b1;
         @(negedge clk);
         total++; if (bus.timeout !== (k == 10))
            begin bad++; $display("FAIL to_pulse cyc=%0d got=%b exp=%b", k, bus.timeout, (k == 10)); end
         if (k == 10) begin
            total++; if (bus.turn !== 1'b1) begin bad++; $display("FAIL to_turn got=%b exp=1", bus.turn); end
         end
      end
      bus.fire = 1'b0; bus.shell = 8'h00;
      @(negedge clk);
      total++; if (bus.timeout !== 1'b0 || bus.turn !== 1'b1)
         begin bad++; $display("FAIL to_fire_wins timeout=%b turn=%b exp 0 1", bus.timeout, bus.turn); end
      repeat (2) @(negedge clk);
      total++; if (bus.turn !== 1'b0) begin bad++; $display("FAIL to_judged_turn got=%b exp=0", bus.turn); end
`else
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         total++; if (bus.timeout !== 1'b0 || bus.turn !== 1'b0)
            begin bad++; $display("FAIL no_timeout cyc=%0d timeout=%b turn=%b exp 0 0", k, bus.timeout, bus.turn); end
      end
`endif
   endtask

   initial begin
      nrst = 1'b1;
      bus.fire = 1'b0; bus.shell = '0; bus.restart = 1'b0;
      bus.tank1_loc = 4'b0001; bus.tank2_loc = 4'b0001;
      test_reset();
      test_hit_and_miss();
      test_loc_change();
      test_game_over();
      test_random();
      test_reset_mid_flight();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
